// File: rtl/hazard_controller.sv
// Stall/flush sequencer for the 5-stage RV32i pipeline: load-use bubbles,
// execute-stage mispredict flushes and DMEM wait freezes with a watchdog.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_controller #(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [REG_ADDR_W-1:0] Rs1_D,
    input  logic [REG_ADDR_W-1:0] Rs2_D,
    input  logic                  Use_Rs1_D,
    input  logic                  Use_Rs2_D,
    input  logic [REG_ADDR_W-1:0] Rd_E,
    input  logic                  Mem_Read_E,
    input  logic                  Mispredict_E,
    input  logic                  Mem_Req_M,
    input  logic                  DMem_Ready,
    output logic                  Stall_F,
    output logic                  Stall_En,
    output logic                  Flush_D,
    output logic                  Flush_E,
    output logic                  Stall_E,
    output logic                  Stall_M,
    output logic                  Mem_Timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      Lu_Stall_Count,
    output logic [CNT_W-1:0]      Flush_Count,
    output logic [CNT_W-1:0]      Mem_Wait_Count
`endif
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1'b1);
    localparam logic [WAIT_W-1:0] WAIT_ZERO = {WAIT_W{1'b0}};
    localparam logic [REG_ADDR_W-1:0] REG_X0 = {REG_ADDR_W{1'b0}};

    typedef enum logic [0:0] {
        ST_RUN       = 1'b0,
        ST_DMEM_WAIT = 1'b1
    } state_t;

    state_t            state_r;
    logic [WAIT_W-1:0] wait_cnt_r;

    logic lu_s;
    logic mw_s;
    logic lu_evt_s;
    logic flush_evt_s;
    logic wait_evt_s;

    // A load writing x0 never creates a dependency
    assign lu_s = Mem_Read_E && (Rd_E != REG_X0) &&
                  ((Use_Rs1_D && (Rs1_D == Rd_E)) || (Use_Rs2_D && (Rs2_D == Rd_E)));
    assign mw_s = Mem_Req_M && !DMem_Ready;

    // Output decode: reset forces every control low, then wait > mispredict > load-use
    always_comb begin
        Stall_F     = 1'b0;
        Stall_En    = 1'b0;
        Flush_D     = 1'b0;
        Flush_E     = 1'b0;
        Stall_E     = 1'b0;
        Stall_M     = 1'b0;
        lu_evt_s    = 1'b0;
        flush_evt_s = 1'b0;
        wait_evt_s  = 1'b0;
        if (RST) begin
            Stall_F = 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (mw_s) begin
                        Stall_F  = 1'b1;
                        Stall_En = 1'b1;
                        Stall_E  = 1'b1;
                        Stall_M  = 1'b1;
                    end else if (Mispredict_E) begin
                        // Decode holds a wrong-path instruction, so no load-use stall
                        Flush_D     = 1'b1;
                        Flush_E     = 1'b1;
                        flush_evt_s = 1'b1;
                    end else if (lu_s) begin
                        Stall_F  = 1'b1;
                        Stall_En = 1'b1;
                        Flush_E  = 1'b1;
                        lu_evt_s = 1'b1;
                    end else begin
                        Stall_F = 1'b0;
                    end
                end
                ST_DMEM_WAIT: begin
                    // Frozen stages keep mispredict/load-use stable until exit
                    Stall_F    = 1'b1;
                    Stall_En   = 1'b1;
                    Stall_E    = 1'b1;
                    Stall_M    = 1'b1;
                    wait_evt_s = 1'b1;
                end
                default: begin
                    Stall_F = 1'b0;
                end
            endcase
        end
    end

    // FSM, saturating wait counter and sticky watchdog flag
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= ST_RUN;
            wait_cnt_r  <= WAIT_ZERO;
            Mem_Timeout <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (mw_s) begin
                        state_r    <= ST_DMEM_WAIT;
                        wait_cnt_r <= WAIT_ONE;
                    end else begin
                        state_r    <= ST_RUN;
                        wait_cnt_r <= WAIT_ZERO;
                    end
                end
                ST_DMEM_WAIT: begin
                    if (DMem_Ready) begin
                        state_r    <= ST_RUN;
                        wait_cnt_r <= WAIT_ZERO;
                    end else if (wait_cnt_r == WAIT_MAX) begin
                        Mem_Timeout <= 1'b1;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WAIT_ONE;
                    end
                end
                default: begin
                    state_r    <= ST_RUN;
                    wait_cnt_r <= WAIT_ZERO;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

    // Event counters, wrapping modulo 2^CNT_W
    always_ff @(posedge CLK) begin
        if (RST) begin
            Lu_Stall_Count <= CNT_ZERO;
            Flush_Count    <= CNT_ZERO;
            Mem_Wait_Count <= CNT_ZERO;
        end else begin
            if (lu_evt_s) begin
                Lu_Stall_Count <= Lu_Stall_Count + CNT_ONE;
            end
            if (flush_evt_s) begin
                Flush_Count <= Flush_Count + CNT_ONE;
            end
            if (wait_evt_s) begin
                Mem_Wait_Count <= Mem_Wait_Count + CNT_ONE;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed self-checking bench for hazard_controller (MEM_TIMEOUT shortened to 4).
module tb_hazard_controller;

    logic       CLK = 1'b0;
    logic       RST;
    logic [4:0] Rs1_D, Rs2_D, Rd_E;
    logic       Use_Rs1_D, Use_Rs2_D, Mem_Read_E, Mispredict_E, Mem_Req_M, DMem_Ready;
    logic       Stall_F, Stall_En, Flush_D, Flush_E, Stall_E, Stall_M, Mem_Timeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] Lu_Stall_Count, Flush_Count, Mem_Wait_Count;
`endif

    int total = 0;
    int bad = 0;

    // {Stall_F, Stall_En, Flush_D, Flush_E, Stall_E, Stall_M}
    logic [5:0] outs;
    assign outs = {Stall_F, Stall_En, Flush_D, Flush_E, Stall_E, Stall_M};

    localparam logic [5:0] O_NONE  = 6'b000000;
    localparam logic [5:0] O_LU    = 6'b110100;
    localparam logic [5:0] O_FLUSH = 6'b001100;
    localparam logic [5:0] O_WAIT  = 6'b110011;

    hazard_controller #(.REG_ADDR_W(5), .MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .CLK(CLK), .RST(RST),
        .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Use_Rs1_D(Use_Rs1_D), .Use_Rs2_D(Use_Rs2_D),
        .Rd_E(Rd_E), .Mem_Read_E(Mem_Read_E), .Mispredict_E(Mispredict_E),
        .Mem_Req_M(Mem_Req_M), .DMem_Ready(DMem_Ready),
        .Stall_F(Stall_F), .Stall_En(Stall_En), .Flush_D(Flush_D), .Flush_E(Flush_E),
        .Stall_E(Stall_E), .Stall_M(Stall_M), .Mem_Timeout(Mem_Timeout)
`ifdef HAZARD_PERF_CNT_EN
        , .Lu_Stall_Count(Lu_Stall_Count), .Flush_Count(Flush_Count),
        .Mem_Wait_Count(Mem_Wait_Count)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        Rs1_D = 5'd0; Rs2_D = 5'd0; Rd_E = 5'd0;
        Use_Rs1_D = 1'b0; Use_Rs2_D = 1'b0; Mem_Read_E = 1'b0;
        Mispredict_E = 1'b0; Mem_Req_M = 1'b0; DMem_Ready = 1'b1;
    endtask

    task automatic set_lu(input logic [4:0] rd);
        Mem_Read_E = 1'b1; Rd_E = rd; Rs2_D = rd; Use_Rs2_D = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        RST = 1'b1;
        set_lu(5'd5);
        Mispredict_E = 1'b1; Mem_Req_M = 1'b1; DMem_Ready = 1'b0;
        #2;
        total++; if (outs !== O_NONE) begin bad++; $display("FAIL reset_outs: got %b want %b", outs, O_NONE); end
        tick();
        total++; if (outs !== O_NONE) begin bad++; $display("FAIL reset_outs2: got %b want %b", outs, O_NONE); end
        total++; if (Mem_Timeout !== 1'b0) begin bad++; $display("FAIL reset_flag: got %b want 0", Mem_Timeout); end
        tick();
        RST = 1'b0;
        idle_inputs();
        #2;
        total++; if (outs !== O_NONE) begin bad++; $display("FAIL reset_idle: got %b want %b", outs, O_NONE); end
        tick();
    endtask

    task automatic test_load_use();
        set_lu(5'd5);
        #2;
        total++; if (outs !== O_LU) begin bad++; $display("FAIL lu_rs2: got %b want %b", outs, O_LU); end
        tick();
        Mem_Read_E = 1'b0;
        #2;
        total++; if (outs !== O_NONE) begin bad++; $display("FAIL lu_release: got %b want %b", outs, O_NONE); end
        tick();
        idle_inputs();
        Mem_Read_E = 1'b1; Rd_E = 5'd12; Rs1_D = 5'd12; Use_Rs1_D = 1'b1; Rs2_D = 5'd3; Use_Rs2_D = 1'b1;
        #2;
        total++; if (outs !== O_LU) begin bad++; $display("FAIL lu_rs1: got %b want %b", outs, O_LU); end
        tick();
        idle_inputs();
    endtask

    task automatic test_no_hazard();
        Mem_Read_E = 1'b1; Rd_E = 5'd0; Rs1_D = 5'd0; Use_Rs1_D = 1'b1;
        #2;
        total++; if (outs !== O_NONE) begin bad++; $display("FAIL lu_x0: got %b want %b", outs, O_NONE); end
        tick();
        Rd_E = 5'd7; Rs1_D = 5'd7; Use_Rs1_D = 1'b0;
        #2;
        total++; if (outs !== O_NONE) begin bad++; $display("FAIL lu_unused: got %b want %b", outs, O_NONE); end
        tick();
        idle_inputs();
    endtask

    task automatic test_mispredict_lu();
        set_lu(5'd9);
        Mispredict_E = 1'b1;
        #2;
        total++; if (outs !== O_FLUSH) begin bad++; $display("FAIL mp_lu: got %b want %b", outs, O_FLUSH); end
        tick();
        idle_inputs();
        #2;
        total++; if (outs !== O_NONE) begin bad++; $display("FAIL mp_once: got %b want %b", outs, O_NONE); end
        tick();
    endtask

    task automatic test_mem_wait_mispredict();
        Mispredict_E = 1'b1; set_lu(5'd4);
        Mem_Req_M = 1'b1; DMem_Ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            DMem_Ready = (i == 3) ? 1'b1 : 1'b0;
            #2;
            total++; if (outs !== O_WAIT) begin bad++; $display("FAIL mw_stall%0d: got %b want %b", i, outs, O_WAIT); end
            tick();
        end
        Mem_Req_M = 1'b0;
        #2;
        total++; if (outs !== O_FLUSH) begin bad++; $display("FAIL mw_exit_flush: got %b want %b", outs, O_FLUSH); end
        total++; if (Mem_Timeout !== 1'b0) begin bad++; $display("FAIL mw_no_timeout: got %b want 0", Mem_Timeout); end
        tick();
        idle_inputs();
    endtask

    task automatic test_timeout();
        Mem_Req_M = 1'b1; DMem_Ready = 1'b0;
        #2;
        total++; if (outs !== O_WAIT) begin bad++; $display("FAIL to_enter: got %b want %b", outs, O_WAIT); end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (Mem_Timeout !== 1'b0) begin bad++; $display("FAIL to_early%0d: got %b want 0", i, Mem_Timeout); end
        end
        tick();
        total++; if (Mem_Timeout !== 1'b1) begin bad++; $display("FAIL to_rise: got %b want 1", Mem_Timeout); end
        total++; if (outs !== O_WAIT) begin bad++; $display("FAIL to_stall: got %b want %b", outs, O_WAIT); end
        DMem_Ready = 1'b1;
        #2;
        total++; if (outs !== O_WAIT) begin bad++; $display("FAIL to_ready_cycle: got %b want %b", outs, O_WAIT); end
        tick();
        Mem_Req_M = 1'b0;
        #2;
        total++; if (outs !== O_NONE) begin bad++; $display("FAIL to_resume: got %b want %b", outs, O_NONE); end
        total++; if (Mem_Timeout !== 1'b1) begin bad++; $display("FAIL to_sticky: got %b want 1", Mem_Timeout); end
        tick();
        Mem_Req_M = 1'b1; DMem_Ready = 1'b0;
        tick();
        RST = 1'b1;
        #2;
        total++; if (outs !== O_NONE) begin bad++; $display("FAIL to_rst_outs: got %b want %b", outs, O_NONE); end
        tick();
        RST = 1'b0;
        Mem_Req_M = 1'b0; DMem_Ready = 1'b1; Mispredict_E = 1'b1;
        #2;
        total++; if (Mem_Timeout !== 1'b0) begin bad++; $display("FAIL to_rst_flag: got %b want 0", Mem_Timeout); end
        total++; if (outs !== O_FLUSH) begin bad++; $display("FAIL to_rst_run: got %b want %b", outs, O_FLUSH); end
        tick();
        idle_inputs();
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf_counters();
        RST = 1'b1; set_lu(5'd6);
        tick();
        RST = 1'b0; idle_inputs();
        #2;
        total++; if (Lu_Stall_Count !== 32'd0) begin bad++; $display("FAIL perf_rst: got %0d want 0", Lu_Stall_Count); end
        for (int i = 0; i < 2; i++) begin
            set_lu(5'd6); tick();
            idle_inputs(); tick();
        end
        Mispredict_E = 1'b1; tick();
        idle_inputs();
        Mem_Req_M = 1'b1; DMem_Ready = 1'b0;
        tick(); tick(); tick();
        DMem_Ready = 1'b1; tick();
        idle_inputs(); tick();
        total++; if (Lu_Stall_Count !== 32'd2) begin bad++; $display("FAIL perf_lu: got %0d want 2", Lu_Stall_Count); end
        total++; if (Flush_Count !== 32'd1) begin bad++; $display("FAIL perf_flush: got %0d want 1", Flush_Count); end
        total++; if (Mem_Wait_Count !== 32'd3) begin bad++; $display("FAIL perf_wait: got %0d want 3", Mem_Wait_Count); end
    endtask
`endif

    initial begin
        idle_inputs();
        RST = 1'b1;
        #1;
        test_reset();
        test_load_use();
        test_no_hazard();
        test_mispredict_lu();
        test_mem_wait_mispredict();
        test_timeout();
`ifdef HAZARD_PERF_CNT_EN
        test_perf_counters();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
